ex_muldiv_unit: RTL and testbench

//   EX-stage iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/ex_muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//   EX-stage iterative multiply/divide unit that owns the architectural HI/LO
//   registers. Multiplies use a shift-add loop and divides use a restoring
//   loop. Both run one iteration per cycle for WIDTH cycles and are followed
//   by a single sign-fix/write-back cycle. MTHI/MTLO write in a single cycle.
//
// Ports
//   Clk    in   1      clock, rising edge
//   Rst    in   1      asynchronous reset, active low
//   Start  in   1      launch Op this cycle (ignored while Busy)
//   Op     in   3      000 MULT,001 MULTU,010 DIV,011 DIVU,
//                      100 MADD,101 MSUB,110 MTHI,111 MTLO
//   Flush  in   1      abort the in-flight op; HI/LO keep their old value
//   A      in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//   B      in   WIDTH  rt operand (divisor / multiplier)
//   Busy   out  1      op in progress (registered, drives the hazard unit)
//   Done   out  1      one-cycle pulse: HI/LO hold a new result this cycle
//   HI     out  WIDTH  HI register
//   LO     out  WIDTH  LO register
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               state_r;
    logic [2:0]           op_r;
    logic [CW-1:0]        count_r;
    // multiplicand for multiplies, divisor for divides (both as magnitudes)
    logic [WIDTH-1:0]     opnd_r;
    // mult: {partial product, remaining multiplier bits}
    // div : {partial remainder, dividend bits shifting into the quotient}
    logic [2*WIDTH:0]     acc_r;
    logic                 res_neg_r;   // product / quotient must be negated
    logic                 rem_neg_r;   // remainder must be negated
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_signed_s;
    logic                 is_div_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_abs_s;
    logic [WIDTH-1:0]     b_abs_s;

    logic                 run_div_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH:0]     mul_next_s;
    logic [2*WIDTH:0]     div_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH:0]     div_next_s;

    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     rem_s;
    logic [2*WIDTH-1:0]   fix_hilo_s;

    // Launch-time operand decode: signedness and magnitudes of A and B.
    always_comb begin
        is_signed_s = (Op == OP_MULT) || (Op == OP_DIV) ||
                      (Op == OP_MADD) || (Op == OP_MSUB);
        is_div_s    = (Op == OP_DIV) || (Op == OP_DIVU);
        a_neg_s     = is_signed_s & A[WIDTH-1];
        b_neg_s     = is_signed_s & B[WIDTH-1];
        // the most negative value maps onto itself, which is the correct magnitude unsigned
        a_abs_s     = a_neg_s ? ({WIDTH{1'b0}} - A) : A;
        b_abs_s     = b_neg_s ? ({WIDTH{1'b0}} - B) : B;
    end

    // One multiply or divide iteration on the working accumulator.
    always_comb begin
        run_div_s   = (op_r == OP_DIV) || (op_r == OP_DIVU);
        // shift-add: add multiplicand to the upper half when the current multiplier bit is set
        mul_sum_s   = acc_r[2*WIDTH:WIDTH] + {1'b0, opnd_r};
        mul_next_s  = acc_r[0] ? ({mul_sum_s, acc_r[WIDTH-1:0]} >> 1)
                               : (acc_r >> 1);
        // restoring divide: trial-subtract the divisor from the shifted remainder
        div_shift_s = {acc_r[2*WIDTH-1:0], 1'b0};
        div_diff_s  = div_shift_s[2*WIDTH:WIDTH] - {1'b0, opnd_r};
        // borrow out of the trial subtraction means restore, quotient bit 0
        div_next_s  = div_diff_s[WIDTH] ? div_shift_s
                                        : {div_diff_s, div_shift_s[WIDTH-1:1], 1'b1};
    end

    // Sign correction and final HI/LO value selected in the FIX cycle.
    always_comb begin
        prod_s = res_neg_r ? ({(2*WIDTH){1'b0}} - acc_r[2*WIDTH-1:0])
                           : acc_r[2*WIDTH-1:0];
        quot_s = res_neg_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0])
                           : acc_r[WIDTH-1:0];
        rem_s  = rem_neg_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                           : acc_r[2*WIDTH-1:WIDTH];
        case (op_r)
            OP_MULT,
            OP_MULTU: fix_hilo_s = prod_s;
            OP_MADD:  fix_hilo_s = {hi_r, lo_r} + prod_s;
            OP_MSUB:  fix_hilo_s = {hi_r, lo_r} - prod_s;
            OP_DIV,
            OP_DIVU:  fix_hilo_s = {rem_s, quot_s};
            default:  fix_hilo_s = {hi_r, lo_r};
        endcase
    end

    // Control FSM, iteration datapath and HI/LO architectural registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'b000;
            count_r   <= '0;
            opnd_r    <= '0;
            acc_r     <= '0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Start && !Flush) begin
                        op_r <= Op;
                        if (Op == OP_MTHI) begin
                            hi_r   <= A;
                            done_r <= 1'b1;
                        end else if (Op == OP_MTLO) begin
                            lo_r   <= A;
                            done_r <= 1'b1;
                        end else if (is_div_s && (B == {WIDTH{1'b0}})) begin
                            // divide by zero: preload the FIX result as quotient=all ones, remainder=A
                            acc_r     <= {1'b0, A, {WIDTH{1'b1}}};
                            res_neg_r <= 1'b0;
                            rem_neg_r <= 1'b0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_FIX;
                        end else begin
                            opnd_r    <= is_div_s ? b_abs_s : a_abs_s;
                            acc_r     <= {{(WIDTH+1){1'b0}}, (is_div_s ? a_abs_s : b_abs_s)};
                            res_neg_r <= a_neg_s ^ b_neg_s;
                            rem_neg_r <= a_neg_s;
                            count_r   <= '0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (Flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r   <= run_div_s ? div_next_s : mul_next_s;
                        count_r <= count_r + CW'(1);
                        if (count_r == CW'(WIDTH - 1)) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                    if (!Flush) begin
                        {hi_r, lo_r} <= fix_hilo_s;
                        done_r       <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//   Self-checking bench for ex_muldiv_unit (WIDTH=32). Directed cases cover
//   the documented examples, divide-by-zero, signed overflow, flush and reset
//   behaviour; a random loop compares every op against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic          Clk;
    logic          Rst;
    logic          Start;
    logic [2:0]    Op;
    logic          Flush;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int            checks;
    int            errors;
    logic [W-1:0]  m_hi;
    logic [W-1:0]  m_lo;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Op    (Op),
        .Flush (Flush),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something never returns.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI,LO} of one op, straight from the arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint      sa, sb, q, rm;
        logic [63:0] ua, ub, uq, ur, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: r = 64'(sa * sb);
            3'd1: r = ua * ub;
            3'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
            3'd4: r = {hi, lo} + 64'(sa * sb);
            3'd5: r = {hi, lo} - 64'(sa * sb);
            3'd6: r = {a, lo};
            default: r = {hi, a};
        endcase
        return r;
    endfunction

    // Launch one op, follow Busy/Done cycle by cycle, then check HI/LO against the model.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] r;
        int          n;
        int          exp_cyc;
        int          busy_bad;
        logic        exp_busy;
        r = ref_result(op, a, b, m_hi, m_lo);
        if (op >= 3'd6) exp_cyc = 1;
        else if ((op == 3'd2 || op == 3'd3) && b == 32'd0) exp_cyc = 2;
        else exp_cyc = W + 2;
        exp_busy = (op >= 3'd6) ? 1'b0 : 1'b1;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        busy_bad = 0;
        while (Done !== 1'b1 && n < 60) begin
            if (Busy !== exp_busy) busy_bad++;
            @(negedge Clk);
            n++;
        end
        check_eq({tag, "_done_cycle"}, 64'(n), 64'(exp_cyc));
        check_eq({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check_eq({tag, "_busy_at_done"}, {63'd0, Busy}, 64'd0);
        m_hi = r[63:32];
        m_lo = r[31:0];
        check_eq({tag, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
        check_eq({tag, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
        @(negedge Clk);
        check_eq({tag, "_done_pulse"}, {63'd0, Done}, 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          done_seen;

        checks = 0; errors = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = '0; B = '0;

        // reset state
        #12;
        check_eq("rst_busy", {63'd0, Busy}, 64'd0);
        check_eq("rst_done", {63'd0, Done}, 64'd0);
        check_eq("rst_hi", {32'd0, HI}, 64'd0);
        check_eq("rst_lo", {32'd0, LO}, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // documented examples with literal expectations as well as the model
        run_op("t1_mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
        check_eq("t1_hi_lit", {32'd0, HI}, 64'hFFFF_FFFF);
        check_eq("t1_lo_lit", {32'd0, LO}, 64'hFFFF_FFFA);
        run_op("t2_multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("t2_lit", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run_op("t3_div", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check_eq("t3_div_lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("t3_divu0", 3'd3, 32'd100, 32'd0);
        check_eq("t3_divu0_lit", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
        run_op("t3_div0", 3'd2, 32'h8000_0005, 32'd0);
        run_op("ovf_div", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("ovf_lit", {HI, LO}, 64'h0000_0000_8000_0000);
        run_op("t4_mthi", 3'd6, 32'd0, 32'd0);
        run_op("t4_mtlo", 3'd7, 32'd10, 32'd0);
        run_op("t4_madd", 3'd4, 32'd3, 32'd4);
        check_eq("t4_madd_lit", {HI, LO}, 64'd22);
        run_op("t4_msub", 3'd5, 32'd5, 32'd5);
        check_eq("t4_msub_lit", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        // randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
            if ((rop == 3'd2 || rop == 3'd3) && $urandom_range(0, 5) == 0) rb = 32'd0;
            run_op("rnd", rop, ra, rb);
        end

        // flush mid-run; a second Start during the run must be ignored
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; A = $urandom; B = $urandom;
        done_seen = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge Clk);
            if (Done === 1'b1) done_seen++;
            if (c == 10) check_eq("fl_busy_c10", {63'd0, Busy}, 64'd1);
            if (c == 11) check_eq("fl_busy_c11", {63'd0, Busy}, 64'd0);
            Start = (c == 5);
            if (c == 5) begin Op = 3'd7; A = 32'hDEAD_BEEF; end
            Flush = (c == 10);
        end
        check_eq("fl_done_never", 64'(done_seen), 64'd0);
        check_eq("fl_hilo", {HI, LO}, {m_hi, m_lo});

        // Flush together with Start in IDLE wins, even for MTHI
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; Op = 3'd6; A = ~m_hi;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        check_eq("fli_done", {63'd0, Done}, 64'd0);
        check_eq("fli_busy", {63'd0, Busy}, 64'd0);
        check_eq("fli_hi", {32'd0, HI}, {32'd0, m_hi});

        // Flush on the FIX exit edge of a divide by zero discards the result
        @(negedge Clk);
        Start = 1'b1; Op = 3'd3; A = 32'h0BAD_F00D; B = 32'd0;
        @(negedge Clk);
        Start = 1'b0;
        check_eq("flx_busy", {63'd0, Busy}, 64'd1);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check_eq("flx_done", {63'd0, Done}, 64'd0);
        check_eq("flx_busy_after", {63'd0, Busy}, 64'd0);
        check_eq("flx_hilo", {HI, LO}, {m_hi, m_lo});

        // Flush on the FIX exit edge of a multiply
        @(negedge Clk);
        Start = 1'b1; Op = 3'd1; A = $urandom; B = $urandom;
        done_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (Done === 1'b1) done_seen++;
            if (c == 34) check_eq("flm_busy_c34", {63'd0, Busy}, 64'd0);
            Start = 1'b0;
            Flush = (c == 33);
        end
        check_eq("flm_done_never", 64'(done_seen), 64'd0);
        check_eq("flm_hilo", {HI, LO}, {m_hi, m_lo});

        // async reset in the middle of a run clears everything at once
        run_op("pre_rst", 3'd6, 32'h5555_AAAA, 32'd0);
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; A = $urandom; B = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        Rst = 1'b0;
        #1;
        check_eq("mrst_busy", {63'd0, Busy}, 64'd0);
        check_eq("mrst_done", {63'd0, Done}, 64'd0);
        check_eq("mrst_hi", {32'd0, HI}, 64'd0);
        check_eq("mrst_lo", {32'd0, LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge Clk);
        Rst = 1'b1;
        run_op("t6_mtlo", 3'd7, 32'h0000_1234, 32'd0);
        check_eq("t6_lo_lit", {32'd0, LO}, 64'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
